// File: rtl/combat_sequencer.sv
// Two-player attack sequencer and hit arbiter: STARTUP/ACTIVE/RECOVERY phases, hit resolution, hitstun, health and KO.
// Optional COMBO_COUNTER_EN macro builds the per-player combo counters; otherwise combo outputs are tied to 0.
module combat_sequencer #(
  parameter int STARTUP_FRAMES  = 3,
  parameter int ACTIVE_FRAMES   = 4,
  parameter int RECOVERY_FRAMES = 8,
  parameter int HITSTUN_FRAMES  = 12,
  parameter int DAMAGE          = 10,
  parameter int HEALTH_MAX      = 100
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       punch_req_p1,
  input  logic       punch_req_p2,
  input  logic       crouch_p1,
  input  logic       crouch_p2,
  input  logic       reach_p1,
  input  logic       reach_p2,
  output logic       punch_p1,
  output logic       punch_p2,
  output logic       hit_p1,
  output logic       hit_p2,
  output logic       stun_p1,
  output logic       stun_p2,
  output logic [6:0] health_p1,
  output logic [6:0] health_p2,
  output logic       ko_p1,
  output logic       ko_p2,
  output logic [3:0] combo_p1,
  output logic [3:0] combo_p2
);

  typedef enum logic [2:0] {IDLE, STARTUP, ACTIVE, RECOVERY, HITSTUN, KO} state_t;

  typedef struct packed {
    state_t     st;
    logic [7:0] cnt;
    logic       landed;
    logic       prev;
    logic [6:0] health;
  } pl_t;

  localparam logic [7:0] ST_LD = 8'(STARTUP_FRAMES - 1);
  localparam logic [7:0] AC_LD = 8'(ACTIVE_FRAMES - 1);
  localparam logic [7:0] RC_LD = 8'(RECOVERY_FRAMES - 1);
  localparam logic [7:0] HS_LD = 8'(HITSTUN_FRAMES - 1);

  function automatic logic [6:0] sat_sub(input logic [6:0] h);
    if (int'(h) <= DAMAGE) return '0;
    return h - 7'(DAMAGE);
  endfunction

  // One player's next state; an incoming hit overrides whatever phase the player was in.
  function automatic pl_t step(input pl_t c, input logic req, input logic conn, input logic hit_in);
    pl_t n = c;
    n.prev = req;
    if (conn) n.landed = 1'b1;
    case (c.st)
      IDLE:
        if (req && !c.prev) begin
          n.st     = STARTUP;
          n.cnt    = ST_LD;
          n.landed = 1'b0;
        end
      STARTUP:
        if (c.cnt == '0) begin n.st = ACTIVE; n.cnt = AC_LD; end
        else n.cnt = c.cnt - 8'd1;
      ACTIVE:
        if (c.cnt == '0) begin n.st = RECOVERY; n.cnt = RC_LD; end
        else n.cnt = c.cnt - 8'd1;
      RECOVERY, HITSTUN:
        if (c.cnt == '0) n.st = IDLE;
        else n.cnt = c.cnt - 8'd1;
      default: ;
    endcase
    if (hit_in) begin
      n.health = sat_sub(c.health);
      n.cnt    = (n.health == '0) ? 8'd0 : HS_LD;
      n.st     = (n.health == '0) ? KO : HITSTUN;
    end
    return n;
  endfunction

  pl_t  p1_q, p1_d, p2_q, p2_d;
  logic conn1, conn2;
  logic punch1_q, punch1_d, punch2_q, punch2_d;
  logic hit1_q, hit1_d, hit2_q, hit2_d;
  logic stun1_q, stun1_d, stun2_q, stun2_d;
  logic ko1_q, ko1_d, ko2_q, ko2_d;

  always_comb begin
    conn1    = (p1_q.st == ACTIVE) && reach_p1 && !crouch_p2 && (p2_q.st != KO) && !p1_q.landed;
    conn2    = (p2_q.st == ACTIVE) && reach_p2 && !crouch_p1 && (p1_q.st != KO) && !p2_q.landed;
    p1_d     = step(p1_q, punch_req_p1, conn1, conn2);
    p2_d     = step(p2_q, punch_req_p2, conn2, conn1);
    punch1_d = (p1_d.st == STARTUP) || (p1_d.st == ACTIVE);
    punch2_d = (p2_d.st == STARTUP) || (p2_d.st == ACTIVE);
    hit1_d   = conn2;
    hit2_d   = conn1;
    stun1_d  = (p1_d.st == HITSTUN);
    stun2_d  = (p2_d.st == HITSTUN);
    ko1_d    = (p1_d.st == KO);
    ko2_d    = (p2_d.st == KO);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      p1_q     <= '{st: IDLE, cnt: 8'd0, landed: 1'b0, prev: 1'b0, health: 7'(HEALTH_MAX)};
      p2_q     <= '{st: IDLE, cnt: 8'd0, landed: 1'b0, prev: 1'b0, health: 7'(HEALTH_MAX)};
      punch1_q <= 1'b0;
      punch2_q <= 1'b0;
      hit1_q   <= 1'b0;
      hit2_q   <= 1'b0;
      stun1_q  <= 1'b0;
      stun2_q  <= 1'b0;
      ko1_q    <= 1'b0;
      ko2_q    <= 1'b0;
    end else begin
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      punch1_q <= punch1_d;
      punch2_q <= punch2_d;
      hit1_q   <= hit1_d;
      hit2_q   <= hit2_d;
      stun1_q  <= stun1_d;
      stun2_q  <= stun2_d;
      ko1_q    <= ko1_d;
      ko2_q    <= ko2_d;
    end
  end

  assign punch_p1  = punch1_q;
  assign punch_p2  = punch2_q;
  assign hit_p1    = hit1_q;
  assign hit_p2    = hit2_q;
  assign stun_p1   = stun1_q;
  assign stun_p2   = stun2_q;
  assign ko_p1     = ko1_q;
  assign ko_p2     = ko2_q;
  assign health_p1 = p1_q.health;
  assign health_p2 = p2_q.health;

`ifdef COMBO_COUNTER_EN
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  logic [3:0] combo1_q, combo1_d, combo2_q, combo2_d;

  // A combo continues only while the victim is still stunned from the previous hit.
  always_comb begin
    combo1_d = combo1_q;
    combo2_d = combo2_q;
    if ((p2_q.st == HITSTUN) && (p2_d.st == IDLE)) combo1_d = '0;
    if ((p1_q.st == HITSTUN) && (p1_d.st == IDLE)) combo2_d = '0;
    if (conn1) combo1_d = (p2_q.st == HITSTUN) ? sat_inc(combo1_q) : 4'd1;
    if (conn2) combo2_d = (p1_q.st == HITSTUN) ? sat_inc(combo2_q) : 4'd1;
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      combo1_q <= '0;
      combo2_q <= '0;
    end else begin
      combo1_q <= combo1_d;
      combo2_q <= combo2_d;
    end
  end

  assign combo_p1 = combo1_q;
  assign combo_p2 = combo2_q;
`else
  assign combo_p1 = '0;
  assign combo_p2 = '0;
`endif

endmodule
